// File: rtl/fp_round_sched.sv
// Round-robin shared 24-bit FP ceil/floor rounding unit; returns the requester tag with each result.
// Latency 2 edges accept->rsp_valid_o, 1/cycle; rsp_ready_i low stalls out, then s1, then req_ready_o.
// Define FP_ROUND_FLOOR_EN to honour req_op_i (floor as -ceil(-x)); otherwise every request is ceil.
module fp_round_sched #(
    parameter int NREQ = 4,
    parameter int TAGW = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [NREQ-1:0]      req_valid_i,
    output logic [NREQ-1:0]      req_ready_o,
    input  logic [NREQ*24-1:0]   req_data_i,
    input  logic [NREQ-1:0]      req_op_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [23:0]          rsp_data_o,
    output logic [TAGW-1:0]      rsp_tag_o,
    output logic                 busy_o
);

    function automatic logic [23:0] ceil24(input logic [23:0] x);
        logic [7:0]  ex;
        logic [14:0] frac;
        logic [14:0] mask;
        logic [7:0]  e;
        logic [22:0] mag;
        ex   = x[22:15];
        frac = x[14:0];
        e    = ex - 8'd127;
        mask = 15'h7FFF >> e;
        // Adding one unit at the lowest integer bit lets the carry ripple into the exponent.
        mag  = {ex, frac & ~mask} + (23'd1 << (8'd15 - e));
        if (ex >= 8'd142 || x[22:0] == 23'd0)
            ceil24 = x;
        else if (ex < 8'd127)
            ceil24 = x[23] ? 24'h800000 : 24'h3F8000;
        else if ((frac & mask) == 15'd0)
            ceil24 = x;
        else if (x[23])
            ceil24 = {1'b1, ex, frac & ~mask};
        else
            ceil24 = {1'b0, mag};
    endfunction

    logic               s1_vld;
    logic               out_vld;
    logic [23:0]        s1_dat;
    logic [TAGW-1:0]    s1_tag;
    logic [TAGW-1:0]    rr_ptr;
    logic [TAGW-1:0]    grant_idx;
    logic [NREQ-1:0]    grant;
    logic [23:0]        sel_dat;
    logic [23:0]        s1_res;
    logic               out_adv;
    logic               s1_adv;
    logic               can_acc;
    logic               acc;
    logic               found;
    int                 idx;
`ifdef FP_ROUND_FLOOR_EN
    logic               sel_op;
    logic               s1_op;
    logic [23:0]        ceil_in;
    logic [23:0]        ceil_out;
`else
    logic               unused_op;
    assign unused_op = ^req_op_i;
`endif

    assign out_adv = !out_vld || rsp_ready_i;
    assign s1_adv  = s1_vld && out_adv;
    assign can_acc = !s1_vld || out_adv;
    assign acc     = |grant;

    // Search starts one past the last winner, so the previous winner has lowest priority.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        sel_dat   = '0;
        found     = 1'b0;
        idx       = 0;
`ifdef FP_ROUND_FLOOR_EN
        sel_op    = 1'b0;
`endif
        for (int k = 1; k <= NREQ; k++) begin
            idx = int'(rr_ptr) + k;
            if (idx >= NREQ)
                idx = idx - NREQ;
            if (can_acc && !found && req_valid_i[idx]) begin
                found      = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = TAGW'(idx);
                sel_dat    = req_data_i[idx*24 +: 24];
`ifdef FP_ROUND_FLOOR_EN
                sel_op     = req_op_i[idx];
`endif
            end
        end
    end

`ifdef FP_ROUND_FLOOR_EN
    assign ceil_in  = {s1_dat[23] ^ s1_op, s1_dat[22:0]};
    assign ceil_out = ceil24(ceil_in);
    assign s1_res   = {ceil_out[23] ^ s1_op, ceil_out[22:0]};
`else
    assign s1_res   = ceil24(s1_dat);
`endif

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            s1_vld     <= 1'b0;
            s1_dat     <= '0;
            s1_tag     <= '0;
            rr_ptr     <= TAGW'(NREQ - 1);
            out_vld    <= 1'b0;
            rsp_data_o <= '0;
            rsp_tag_o  <= '0;
`ifdef FP_ROUND_FLOOR_EN
            s1_op      <= 1'b0;
`endif
        end else begin
            if (acc) begin
                s1_vld <= 1'b1;
                s1_dat <= sel_dat;
                s1_tag <= grant_idx;
                rr_ptr <= grant_idx;
`ifdef FP_ROUND_FLOOR_EN
                s1_op  <= sel_op;
`endif
            end else if (s1_adv) begin
                s1_vld <= 1'b0;
            end
            if (s1_adv) begin
                out_vld    <= 1'b1;
                rsp_data_o <= s1_res;
                rsp_tag_o  <= s1_tag;
            end else if (out_adv) begin
                out_vld    <= 1'b0;
            end
        end
    end

    assign req_ready_o = grant;
    assign rsp_valid_o = out_vld;
    assign busy_o      = s1_vld || out_vld;

endmodule

// File: tb/tb_fp_round_sched.sv
// Bench for fp_round_sched: real-arithmetic rounding model plus an in-order scoreboard checked every cycle,
// and directed scenarios (vector table, back-to-back grants, stall, reset mid-flight, single streamer).
module tb_fp_round_sched;
    localparam int NREQ = 4;
    localparam int TAGW = 2;
`ifdef FP_ROUND_FLOOR_EN
    localparam bit FLOOR_EN = 1'b1;
`else
    localparam bit FLOOR_EN = 1'b0;
`endif

    logic               clk_i = 1'b0;
    logic               rst_i = 1'b1;
    logic [NREQ-1:0]    req_valid_i = '0;
    logic [NREQ-1:0]    req_ready_o;
    logic [NREQ*24-1:0] req_data_i = '0;
    logic [NREQ-1:0]    req_op_i = '0;
    logic               rsp_valid_o;
    logic               rsp_ready_i = 1'b1;
    logic [23:0]        rsp_data_o;
    logic [TAGW-1:0]    rsp_tag_o;
    logic               busy_o;

    typedef struct { logic [23:0] dat; int tag; int acc; } exp_t;
    typedef struct { logic [23:0] dat; int tag; time t; } rsp_t;
    typedef struct { logic [23:0] x; logic op; logic [23:0] lit; } vec_t;

    exp_t            sb[$];
    rsp_t            rsp_log[$];
    vec_t            vecs[$];
    int              n_checks = 0;
    int              n_fail = 0;
    int              cyc = 0;
    int              rr_m = NREQ - 1;
    logic [NREQ-1:0] acc_now = '0;
    time             acc_t = 0;

    fp_round_sched #(.NREQ(NREQ), .TAGW(TAGW)) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .req_valid_i (req_valid_i),
        .req_ready_o (req_ready_o),
        .req_data_i  (req_data_i),
        .req_op_i    (req_op_i),
        .rsp_valid_o (rsp_valid_o),
        .rsp_ready_i (rsp_ready_i),
        .rsp_data_o  (rsp_data_o),
        .rsp_tag_o   (rsp_tag_o),
        .busy_o      (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic real fp_to_real(input logic [23:0] x);
        real v;
        int  ex;
        ex = int'(x[22:15]);
        if (ex == 0) begin
            v  = real'(int'(x[14:0])) / 32768.0;
            ex = 1;
        end else begin
            v = 1.0 + real'(int'(x[14:0])) / 32768.0;
        end
        for (int i = ex; i > 127; i--) v = v * 2.0;
        for (int i = ex; i < 127; i++) v = v / 2.0;
        return x[23] ? -v : v;
    endfunction

    function automatic logic [23:0] real_to_fp(input real r, input logic zero_sign);
        real a;
        real p;
        int  e;
        int  f;
        if (r == 0.0) return {zero_sign, 23'd0};
        a = (r < 0.0) ? -r : r;
        p = 1.0;
        e = 0;
        while (p * 2.0 <= a) begin
            p = p * 2.0;
            e++;
        end
        f = int'((a / p - 1.0) * 32768.0);
        return {r < 0.0, 8'(127 + e), 15'(f)};
    endfunction

    function automatic logic [23:0] model_round(input logic [23:0] x, input logic op);
        if (x[22:15] == 8'hFF || x[22:15] >= 8'd142 || x[22:0] == 23'd0) return x;
        if (FLOOR_EN && op) return real_to_fp($floor(fp_to_real(x)), 1'b0);
        return real_to_fp($ceil(fp_to_real(x)), x[23]);
    endfunction

    function automatic int oh_idx(input logic [NREQ-1:0] v);
        for (int i = 0; i < NREQ; i++) if (v[i]) return i;
        return -1;
    endfunction

    // Per-cycle comparison against the scoreboard; items become visible two edges after acceptance.
    always @(negedge clk_i) begin : model_cmp
        logic exp_vld;
        logic s1_full;
        logic can_acc;
        int   g;
        int   idx;
        exp_t e;
        cyc++;
        if (rst_i) begin
            sb.delete();
            rr_m = NREQ - 1;
            check("rst_rsp_valid", 32'(rsp_valid_o), 0);
            check("rst_busy", 32'(busy_o), 0);
            check("rst_rsp_data", 32'(rsp_data_o), 0);
            check("rst_rsp_tag", 32'(rsp_tag_o), 0);
        end else begin
            exp_vld = (sb.size() > 0) && (sb[0].acc + 2 <= cyc);
            check("rsp_valid", 32'(rsp_valid_o), 32'(exp_vld));
            check("busy", 32'(busy_o), 32'(sb.size() > 0));
            if (exp_vld) begin
                check("rsp_data", 32'(rsp_data_o), 32'(sb[0].dat));
                check("rsp_tag", 32'(rsp_tag_o), sb[0].tag);
            end
            s1_full = (sb.size() == 2) || (sb.size() == 1 && !exp_vld);
            can_acc = !s1_full || !exp_vld || rsp_ready_i;
            g = -1;
            if (can_acc) begin
                for (int k = 1; k <= NREQ; k++) begin
                    idx = (rr_m + k) % NREQ;
                    if (g < 0 && req_valid_i[idx]) g = idx;
                end
            end
            check("req_ready", 32'(req_ready_o), (g >= 0) ? (1 << g) : 0);
            if (exp_vld && rsp_ready_i) void'(sb.pop_front());
            if (g >= 0) begin
                e.dat = model_round(req_data_i[g*24 +: 24], req_op_i[g]);
                e.tag = g;
                e.acc = cyc;
                sb.push_back(e);
                rr_m = g;
            end
        end
    end

    always @(negedge clk_i) begin : rsp_mon
        rsp_t r;
        if (!rst_i && rsp_valid_o && rsp_ready_i) begin
            r.dat = rsp_data_o;
            r.tag = int'(rsp_tag_o);
            r.t   = $time;
            rsp_log.push_back(r);
        end
    end

    task automatic step();
        @(negedge clk_i);
        acc_now = req_valid_i & req_ready_o;
        if (acc_now != '0) acc_t = $time;
        @(posedge clk_i);
        #1;
        req_valid_i = req_valid_i & ~acc_now;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy_o || req_valid_i != '0) && n < 40) begin
            step();
            n++;
        end
        check(name, 32'(n < 40), 1);
    endtask

    task automatic reset_dut();
        req_valid_i = '0;
        rst_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
    endtask

    task automatic add_vec(input logic [23:0] x, input logic op, input logic [23:0] lit);
        vec_t v;
        v.x = x;
        v.op = op;
        v.lit = lit;
        vecs.push_back(v);
    endtask

    task automatic check_rsps(input string name, input int base, input int n,
                              input int t0, input int t1, input int t2,
                              input logic [23:0] d0, input logic [23:0] d1, input logic [23:0] d2);
        int          tags[3];
        logic [23:0] dats[3];
        tags = '{t0, t1, t2};
        dats = '{d0, d1, d2};
        check({name, "_count"}, rsp_log.size(), base + n);
        if (rsp_log.size() == base + n) begin
            for (int k = 0; k < n; k++) begin
                check({name, "_tag"}, rsp_log[base+k].tag, tags[k]);
                check({name, "_data"}, 32'(rsp_log[base+k].dat), 32'(dats[k]));
            end
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int          r;
        int          base;
        int          sent;
        time         ta;
        int          gr_q[$];
        time         gt_q[$];
        logic [23:0] stream_v[3];

        add_vec(24'h3FC000, 1'b0, 24'h400000);
        add_vec(24'hBFC000, 1'b0, 24'hBF8000);
        add_vec(24'h3E8000, 1'b0, 24'h3F8000);
        add_vec(24'hBE8000, 1'b0, 24'h800000);
        add_vec(24'h478000, 1'b0, 24'h478000);
        add_vec(24'h7F8000, 1'b0, 24'h7F8000);
        add_vec(24'h3FF800, 1'b0, 24'h400000);
        add_vec(24'h46FFFF, 1'b0, 24'h470000);
        add_vec(24'h000000, 1'b0, 24'h000000);
        add_vec(24'h800000, 1'b0, 24'h800000);
        add_vec(24'h000001, 1'b0, 24'h3F8000);
        add_vec(24'h800001, 1'b0, 24'h800000);
`ifdef FP_ROUND_FLOOR_EN
        add_vec(24'h3FC000, 1'b1, 24'h3F8000);
        add_vec(24'hBFC000, 1'b1, 24'hC00000);
        add_vec(24'h3E8000, 1'b1, 24'h000000);
        add_vec(24'hBE8000, 1'b1, 24'hBF8000);
`else
        add_vec(24'h3FC000, 1'b1, 24'h400000);
        add_vec(24'hBFC000, 1'b1, 24'hBF8000);
`endif

        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        // Directed vectors, one at a time, rotating over requesters.
        for (int i = 0; i < vecs.size(); i++) begin
            r = i % NREQ;
            base = rsp_log.size();
            check("model_pin", 32'(model_round(vecs[i].x, vecs[i].op)), 32'(vecs[i].lit));
            req_data_i[r*24 +: 24] = vecs[i].x;
            req_op_i[r] = vecs[i].op;
            req_valid_i[r] = 1'b1;
            wait_idle("dir_timeout");
            ta = acc_t;
            check("dir_count", rsp_log.size(), base + 1);
            if (rsp_log.size() == base + 1) begin
                check("dir_data", 32'(rsp_log[base].dat), 32'(vecs[i].lit));
                check("dir_tag", rsp_log[base].tag, r);
                check("dir_latency", 32'(rsp_log[base].t - ta), 20);
            end
        end
        req_op_i = '0;

        // Reqs 0,1,2 from reset: consecutive grants and back-to-back responses.
        reset_dut();
        req_data_i[0*24 +: 24] = 24'h3FC000;
        req_data_i[1*24 +: 24] = 24'hBFC000;
        req_data_i[2*24 +: 24] = 24'h3E8000;
        base = rsp_log.size();
        req_valid_i = 4'b0111;
        for (int n = 0; n < 10 && req_valid_i != '0; n++) begin
            step();
            if (acc_now != '0) begin
                gr_q.push_back(oh_idx(acc_now));
                gt_q.push_back(acc_t);
            end
        end
        wait_idle("bb_timeout");
        check("bb_grants", gr_q.size(), 3);
        if (gr_q.size() == 3) begin
            for (int k = 0; k < 3; k++) begin
                check("bb_grant_order", gr_q[k], k);
                check("bb_grant_gap", 32'(gt_q[k] - gt_q[0]), 10 * k);
            end
        end
        check_rsps("bb_rsp", base, 3, 0, 1, 2, 24'h400000, 24'hBF8000, 24'h3F8000);
        if (rsp_log.size() == base + 3)
            check("bb_rsp_gap", 32'(rsp_log[base+2].t - rsp_log[base].t), 20);

        // Consumer stall with three requesters pending (pointer now at 2 -> order 3,0,1).
        req_data_i[3*24 +: 24] = 24'h478000;
        req_data_i[0*24 +: 24] = 24'h3FF800;
        req_data_i[1*24 +: 24] = 24'hBE8000;
        base = rsp_log.size();
        sent = 0;
        rsp_ready_i = 1'b0;
        req_valid_i = 4'b1011;
        for (int n = 0; n < 5; n++) begin
            step();
            if (acc_now != '0) sent++;
        end
        check("stall_accepted", sent, 2);
        check("stall_req_ready", 32'(req_ready_o), 0);
        check("stall_rsp_valid", 32'(rsp_valid_o), 1);
        check("stall_rsp_data", 32'(rsp_data_o), 32'h478000);
        check("stall_rsp_tag", 32'(rsp_tag_o), 3);
        rsp_ready_i = 1'b1;
        wait_idle("stall_timeout");
        check_rsps("stall_rsp", base, 3, 3, 0, 1, 24'h478000, 24'h400000, 24'h800000);

        // Reset with both stages full: everything discarded and the pointer restored.
        req_data_i[0*24 +: 24] = 24'h3FC000;
        req_data_i[1*24 +: 24] = 24'hBFC000;
        rsp_ready_i = 1'b0;
        req_valid_i = 4'b0011;
        repeat (3) step();
        check("pre_rst_busy", 32'(busy_o), 1);
        check("pre_rst_rsp_valid", 32'(rsp_valid_o), 1);
        rst_i = 1'b1;
        req_valid_i = '0;
        #1;
        check("rst_async_rsp_valid", 32'(rsp_valid_o), 0);
        check("rst_async_busy", 32'(busy_o), 0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;
        rsp_ready_i = 1'b1;
        base = rsp_log.size();
        repeat (5) step();
        check("rst_no_rsp", rsp_log.size(), base);
        req_data_i[1*24 +: 24] = 24'h3E8000;
        req_data_i[3*24 +: 24] = 24'hBE8000;
        req_valid_i = 4'b1010;
        gr_q.delete();
        for (int n = 0; n < 10 && req_valid_i != '0; n++) begin
            step();
            if (acc_now != '0) gr_q.push_back(oh_idx(acc_now));
        end
        check("rst_first_grant", (gr_q.size() > 0) ? gr_q[0] : -1, 1);
        wait_idle("rst_timeout");
        check_rsps("rst_rsp", base, 2, 1, 3, 0, 24'h3F8000, 24'h800000, 24'h000000);

        // One requester streaming wins every cycle.
        stream_v = '{24'h3FF800, 24'h000001, 24'h46FFFF};
        base = rsp_log.size();
        sent = 0;
        gt_q.delete();
        req_data_i[2*24 +: 24] = stream_v[0];
        req_valid_i = 4'b0100;
        for (int n = 0; n < 10 && sent < 3; n++) begin
            step();
            if (acc_now[2]) begin
                gt_q.push_back(acc_t);
                sent++;
                if (sent < 3) begin
                    req_data_i[2*24 +: 24] = stream_v[sent];
                    req_valid_i[2] = 1'b1;
                end
            end
        end
        wait_idle("stream_timeout");
        check("stream_sent", sent, 3);
        if (gt_q.size() == 3) check("stream_gap", 32'(gt_q[2] - gt_q[0]), 20);
        check_rsps("stream_rsp", base, 3, 2, 2, 2, 24'h400000, 24'h3F8000, 24'h470000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
